// File: rtl/dcm_cfg_pkg.sv
// dcm_cfg_pkg: shared request-op encodings, sequencer states and default timeouts
// for the DCM configuration sequencer.
package dcm_cfg_pkg;
    typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_PS = 2'd2, OP_RST = 2'd3} op_e;
    typedef enum logic [2:0] {RST_HOLD, LOCK_WAIT, IDLE, DRP_WAIT, PS_WAIT, RESP} state_e;
    localparam int DRP_TIMEOUT_DEF  = 1024;
    localparam int RST_HOLD_DEF     = 4;
    localparam int LOCK_TIMEOUT_DEF = 65535;
endpackage

// File: rtl/dcm_cfg_timer.sv
// dcm_cfg_timer: loadable saturating 16-bit counter; term is high once the count
// reaches limit.
module dcm_cfg_timer
    import dcm_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic [15:0] limit,
    output logic        term
);
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (en && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign term = cnt_q >= limit;
endmodule

// File: rtl/dcm_cfg_seq.sv
// dcm_cfg_seq: DRP read/write, phase-step and DCM reset sequencer with timeouts.
// Define DCM_CFG_SEQ_AUTORELOCK_EN to relock automatically when LOCKED drops in IDLE.
module dcm_cfg_seq
    import dcm_cfg_pkg::*;
#(
    parameter int DRP_TIMEOUT     = DRP_TIMEOUT_DEF,
    parameter int RST_HOLD_CYCLES = RST_HOLD_DEF,
    parameter int LOCK_TIMEOUT    = LOCK_TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OP,
    input  logic [6:0]  REQ_ADDR,
    input  logic [15:0] REQ_DATA,
    input  logic        REQ_INCDEC,
    output logic        RSP_VALID,
    output logic [15:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic        BUSY,
    output logic        LOCK_LOST,
    output logic [6:0]  DADDR,
    output logic [15:0] DI,
    output logic        DEN,
    output logic        DWE,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic        PSEN,
    output logic        PSINCDEC,
    input  logic        PSDONE,
    output logic        DCM_RST,
    input  logic        LOCKED
);
    localparam logic [15:0] HOLD_LIM = 16'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] DRP_LIM  = 16'(DRP_TIMEOUT);
    localparam logic [15:0] LOCK_LIM = 16'(LOCK_TIMEOUT);
    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d, rsp_data_q, rsp_data_d;
    logic        den_q, den_d, dwe_q, dwe_d, psen_q, psen_d, psinc_q, psinc_d;
    logic        dcm_rst_q, dcm_rst_d, rsp_err_q, rsp_err_d, silent_q, silent_d;
    logic        drop, accept, term;
    logic [15:0] limit;
`ifdef DCM_CFG_SEQ_AUTORELOCK_EN
    logic locked_q, lock_lost_q, lock_lost_d;
    assign drop        = state_q == IDLE && locked_q && !LOCKED;
    assign lock_lost_d = lock_lost_q | drop;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            locked_q    <= LOCKED;
            lock_lost_q <= lock_lost_d;
        end
    end
    assign LOCK_LOST = lock_lost_q;
`else
    assign drop      = 1'b0;
    assign LOCK_LOST = 1'b0;
`endif
    assign REQ_READY = state_q == IDLE && !drop;
    assign accept    = REQ_VALID && REQ_READY;
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        den_d      = 1'b0;
        dwe_d      = 1'b0;
        psen_d     = 1'b0;
        psinc_d    = psinc_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        silent_d   = silent_q;
        case (state_q)
            RST_HOLD:  if (term) state_d = LOCK_WAIT;
            // power-on and auto-relock sequences return to IDLE without a response
            LOCK_WAIT: if (LOCKED || term) begin
                state_d    = silent_q ? IDLE : RESP;
                rsp_err_d  = !LOCKED;
                rsp_data_d = '0;
            end
            IDLE: if (drop) begin
                state_d  = RST_HOLD;
                silent_d = 1'b1;
            end else if (accept) begin
                op_d     = op_e'(REQ_OP);
                addr_d   = REQ_ADDR;
                data_d   = REQ_DATA;
                silent_d = 1'b0;
                case (op_e'(REQ_OP))
                    OP_RD, OP_WR: begin
                        den_d   = 1'b1;
                        dwe_d   = REQ_OP[0];
                        state_d = DRP_WAIT;
                    end
                    OP_PS: if (LOCKED) begin
                        psen_d  = 1'b1;
                        psinc_d = REQ_INCDEC;
                        state_d = PS_WAIT;
                    end else begin
                        state_d    = RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end
                    OP_RST: state_d = RST_HOLD;
                endcase
            end
            DRP_WAIT: if (DRDY || term) begin
                state_d    = RESP;
                rsp_err_d  = !DRDY;
                rsp_data_d = (DRDY && op_q == OP_RD) ? DO : '0;
            end
            PS_WAIT: if (PSDONE || term) begin
                state_d    = RESP;
                rsp_err_d  = !PSDONE;
                rsp_data_d = '0;
                psinc_d    = 1'b0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        dcm_rst_d = state_d == RST_HOLD;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= RST_HOLD;
            op_q       <= OP_RD;
            addr_q     <= '0;
            data_q     <= '0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            psen_q     <= 1'b0;
            psinc_q    <= 1'b0;
            dcm_rst_q  <= 1'b1;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            silent_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            psen_q     <= psen_d;
            psinc_q    <= psinc_d;
            dcm_rst_q  <= dcm_rst_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            silent_q   <= silent_d;
        end
    end
    // one counter serves every wait state; reloaded to zero on each state change
    assign limit = state_q == RST_HOLD ? HOLD_LIM : state_q == LOCK_WAIT ? LOCK_LIM : DRP_LIM;
    dcm_cfg_timer u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (state_d != state_q),
        .load_val (16'd0),
        .en       (1'b1),
        .limit    (limit),
        .term     (term)
    );
    assign DADDR     = addr_q;
    assign DI        = data_q;
    assign DEN       = den_q;
    assign DWE       = dwe_q;
    assign PSEN      = psen_q;
    assign PSINCDEC  = psinc_q;
    assign DCM_RST   = dcm_rst_q;
    assign RSP_VALID = state_q == RESP;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign BUSY      = state_q != IDLE;
endmodule
